// File: rtl/num_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : num_scan_pkg
//  Description : Shared widths, FSM state type and helper for the number
//                scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package num_scan_pkg;

    localparam int NUM_W = 5;   // width of the scanned value
    localparam int CNT_W = 6;   // width of the hit counter (holds up to 32)

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_DWELL   = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // True for the states in which a scan is in progress and can be aborted.
    function automatic logic is_busy_state(input state_t s);
        return (s == ST_LOAD) || (s == ST_DWELL) ||
               (s == ST_SAMPLE) || (s == ST_ADVANCE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/num_scan_ctrl_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Loadable down-counter that holds each scan value for a
//                programmable number of extra cycles. Saturates at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority; decrement only while enabled and not yet at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/num_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : num_scan_ctrl
//  Description : Steps a value from lo to hi through an external number
//                detector, sampling the returned LED pattern once per value
//                and counting non-zero responses. Auto mode dwells a fixed
//                number of cycles per value; manual mode waits for step.
//  Revision    : 1.0 - initial release
// ============================================================================
module num_scan_ctrl
    import num_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic               step,
    input  logic [NUM_W-1:0]   lo,
    input  logic [NUM_W-1:0]   hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_W-1:0]   led_in,
    output logic [NUM_W-1:0]   num,
    output logic [NUM_W-1:0]   led_latched,
    output logic [CNT_W-1:0]   hit_count,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             r_state;
    logic               r_mode;
    logic [NUM_W-1:0]   r_lo;
    logic [NUM_W-1:0]   r_hi;
    logic [DWELL_W-1:0] r_dwell;

    logic w_tmr_load;
    logic w_tmr_en;
    logic w_tmr_zero;

    // Timer is (re)armed whenever a new value is about to be presented and
    // only counts while dwelling in auto mode.
    always_comb begin
        w_tmr_load = (r_state == ST_LOAD) || (r_state == ST_ADVANCE);
        w_tmr_en   = (r_state == ST_DWELL) && r_mode && !w_tmr_zero;
    end

    dwell_timer #(
        .WIDTH (DWELL_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_tmr_load),
        .value (r_dwell),
        .en    (w_tmr_en),
        .zero  (w_tmr_zero)
    );

    // Scan sequencer with registered outputs; abort overrides every busy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= 1'b0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_dwell     <= '0;
            num         <= '0;
            led_latched <= '0;
            hit_count   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && is_busy_state(r_state)) begin
                r_state <= ST_IDLE;
                num     <= '0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (lo <= hi) begin
                                r_state <= ST_LOAD;
                                busy    <= 1'b1;
                                r_mode  <= mode;
                                r_lo    <= lo;
                                r_hi    <= hi;
                                r_dwell <= dwell;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        num       <= r_lo;
                        hit_count <= '0;
                        r_state   <= ST_DWELL;
                    end
                    ST_DWELL: begin
                        if (r_mode ? w_tmr_zero : step) begin
                            r_state <= ST_SAMPLE;
                        end
                    end
                    ST_SAMPLE: begin
                        led_latched <= led_in;
                        if (led_in != '0) begin
                            hit_count <= hit_count + CNT_W'(1);
                        end
                        r_state <= ST_ADVANCE;
                    end
                    ST_ADVANCE: begin
                        // Compare before incrementing so hi=31 never wraps num.
                        if (num == r_hi) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            num     <= num + NUM_W'(1);
                            r_state <= ST_DWELL;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        num     <= '0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        num     <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/num_scan_ctrl.md
NUM_SCAN_CTRL -- requirements
Module: num_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, width of the dwell counter.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  in  1  one-cycle request to begin a scan.
REQ-005 SHALL have port abort  in  1  one-cycle request to cancel a scan.
REQ-006 SHALL have port mode  in  1  scan mode: 0 = manual step, 1 = auto.
REQ-007 SHALL have port step  in  1  one-cycle advance pulse, manual mode only.
REQ-008 SHALL have port lo  in  5  first value of the scan.
REQ-009 SHALL have port hi  in  5  last value of the scan.
REQ-010 SHALL have port dwell  in  DWELL_W  extra hold cycles per value in auto mode.
REQ-011 SHALL have port led_in  in  5  LED pattern returned by the external number detector.
REQ-012 SHALL have port num  out  5  value driven to the external number detector.
REQ-013 SHALL have port led_latched  out  5  last sampled led_in.
REQ-014 SHALL have port hit_count  out  6  count of sampled values with led_in != 0.
REQ-015 SHALL have port busy / done / err  out  1 each  scan active / one-cycle completion pulse / one-cycle bad-range pulse.

Function
REQ-016 SHALL implement the states IDLE, LOAD, DWELL, SAMPLE, ADVANCE and DONE.
REQ-017 In IDLE: busy=0, num=0; start with lo<=hi -> LOAD; start with lo>hi -> stay in IDLE and pulse err for 1 cycle.
REQ-018 SHALL capture mode, lo, hi and dwell on an accepted start; later changes to these inputs have no effect until the next start.
REQ-019 In LOAD: num<=lo, hit_count<=0, dwell counter<=dwell; then -> DWELL.
REQ-020 In DWELL, auto mode: decrement the counter each cycle and go to SAMPLE on the cycle the counter equals 0, giving dwell+1 cycles in DWELL (dwell=0 gives 1 cycle).
REQ-021 In DWELL, manual mode: hold until step=1, then -> SAMPLE; step in any other state is ignored.
REQ-022 In SAMPLE: led_latched<=led_in; hit_count increments when led_in != 0; then -> ADVANCE.
REQ-023 In ADVANCE: if num==hi -> DONE; else num<=num+1, reload the dwell counter, -> DWELL.
REQ-024 SHALL compare before incrementing, so hi=31 ends the scan without num wrapping to 0.
REQ-025 In auto mode, each value SHALL occupy exactly dwell+3 cycles, and a full scan SHALL take 1 + (hi-lo+1)*(dwell+3) cycles from LOAD to DONE.
REQ-026 In DONE: done=1 for exactly 1 cycle, num keeps the last value, then -> IDLE.
REQ-027 busy SHALL be 1 in LOAD, DWELL, SAMPLE and ADVANCE only.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort in any busy state SHALL return the block to IDLE on the next edge with no done pulse; hit_count and led_latched keep their values.
REQ-030 abort and start in the same cycle while in IDLE SHALL let start win; abort in IDLE has no effect.
REQ-031 hit_count SHALL NOT overflow, since at most 32 values are sampled (maximum 32 fits in 6 bits).

Reset
REQ-032 Asserting rst SHALL force, immediately and regardless of clk, state=IDLE, num=0, led_latched=0, hit_count=0, busy=0, done=0, err=0 and counter=0.
REQ-033 Asserting rst mid-scan SHALL abandon the scan; after release the block waits for a new start.

Structure
REQ-034 Package num_scan_pkg SHALL hold NUM_W=5, the state enum type and CNT_W=6.
REQ-035 The dwell counter SHALL be one sub-module, dwell_timer (inputs load, value, en; output zero).
REQ-036 The number detector SHALL stay external, connected through num and led_in.

Verification
REQ-037 Bench SHALL cover: rst mid-scan -> all outputs 0 immediately, IDLE after release.
REQ-038 Bench SHALL cover, using a detector model with led_in=5'b00001 only when num==5: auto, lo=0, hi=10, dwell=2 -> num steps 0..10, each held 5 cycles; done at cycle 56 after LOAD; hit_count=1.
REQ-039 Bench SHALL cover: manual, lo=3, hi=5, three step pulses -> num 3,4,5, then done; fewer pulses -> busy stays 1.
REQ-040 Bench SHALL cover: start with lo=20, hi=10 -> err for 1 cycle, busy stays 0.
REQ-041 Bench SHALL cover: auto, lo=30, hi=31, dwell=0 -> num 30,31, done, no wrap to 0.
REQ-042 Bench SHALL cover: abort while num=7 -> IDLE next cycle, no done pulse, num=0.
